// File: rtl/gray_ptr_ctrl_pkg.sv
// Shared definitions for the async-FIFO pointer controller.
//   MODE_WR / MODE_RD : side selector for gray_ptr_ctrl.
//   bin2gray          : binary to reflected Gray code.
//   gray2bin          : Gray code to binary (prefix XOR from the MSB down).
// Both converters work on a fixed wide vector. Callers zero-extend their
// operand and truncate the result; leading zeros do not affect either
// conversion.
package gray_ptr_ctrl_pkg;

    localparam int MODE_WR = 0;
    localparam int MODE_RD = 1;
    localparam int CODE_W  = 32;

    function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
        logic [CODE_W-1:0] b;
        b[CODE_W-1] = g[CODE_W-1];
        for (int i = CODE_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_ptr_ctrl_sync.sv
// Multi-flop synchroniser for a Gray-coded bus from another clock domain.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears every stage to 0
//   d   : bus from the remote domain (asynchronous to clk)
//   q   : output of the last stage
module cdc_sync_bus #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_ctrl.sv
// Pointer / flag controller for one side of an asynchronous FIFO.
// MODE 0 (write side) raises full and almost-full; MODE 1 (read side)
// raises empty and almost-empty. Only ptr_gray may cross to the other
// clock domain.
//   clk         : domain clock
//   rst         : asynchronous active-high reset
//   inc         : push (MODE 0) / pop (MODE 1) request
//   remote_gray : Gray pointer of the other domain
//   ptr_gray    : registered local Gray pointer
//   addr        : RAM address (low bits of the binary pointer)
//   flag        : full (MODE 0) / empty (MODE 1), registered
//   almost      : almost-full / almost-empty, registered
//   level       : occupancy estimate 0..depth, registered
//   err         : one-cycle pulse after a rejected request
module gray_ptr_ctrl
    import gray_ptr_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 7,
    parameter int MODE        = 0,
    parameter int SYNC_STAGES = 2,
    parameter int ALMOST_TH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    input  logic [ADDR_WIDTH:0]   remote_gray,
    output logic [ADDR_WIDTH:0]   ptr_gray,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  flag,
    output logic                  almost,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  err
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PTR_W-1:0] ALM_WR_LVL = PTR_W'(DEPTH - ALMOST_TH);
    localparam logic [PTR_W-1:0] ALM_RD_LVL = PTR_W'(ALMOST_TH);
    // Read side comes out of reset empty, write side not full.
    localparam logic FLAG_RST = (MODE == MODE_RD);

    logic [PTR_W-1:0] rsync;
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] full_pat;
    logic             inc_eff;

    logic [PTR_W-1:0] bin_q,   bin_d;
    logic [PTR_W-1:0] gray_q,  gray_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic             flag_q,  flag_d;
    logic             almost_q, almost_d;
    logic             err_q,   err_d;

    cdc_sync_bus #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (remote_gray),
        .q   (rsync)
    );

    always_comb begin
        inc_eff = inc & ~flag_q;
        bin_d   = bin_q + {{(PTR_W-1){1'b0}}, inc_eff};
        gray_d  = PTR_W'(bin2gray(CODE_W'(bin_d)));
        rbin    = PTR_W'(gray2bin(CODE_W'(rsync)));
        // Full when the write pointer is exactly one lap ahead: in Gray
        // code that is the remote pointer with its top two bits inverted.
        full_pat = {~rsync[PTR_W-1:PTR_W-2], rsync[PTR_W-3:0]};
        err_d    = inc & flag_q;
        if (MODE == MODE_WR) begin
            level_d  = bin_d - rbin;
            flag_d   = (gray_d == full_pat);
            almost_d = (level_d >= ALM_WR_LVL);
        end else begin
            level_d  = rbin - bin_d;
            flag_d   = (gray_d == rsync);
            almost_d = (level_d <= ALM_RD_LVL);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q    <= '0;
            gray_q   <= '0;
            level_q  <= '0;
            flag_q   <= FLAG_RST;
            almost_q <= FLAG_RST;
            err_q    <= 1'b0;
        end else begin
            bin_q    <= bin_d;
            gray_q   <= gray_d;
            level_q  <= level_d;
            flag_q   <= flag_d;
            almost_q <= almost_d;
            err_q    <= err_d;
        end
    end

    assign ptr_gray = gray_q;
    assign addr     = bin_q[ADDR_WIDTH-1:0];
    assign flag     = flag_q;
    assign almost   = almost_q;
    assign level    = level_q;
    assign err      = err_q;

endmodule
